// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, round-constant seed, controller
// state encoding and the GF(2^8) doubling used by both the key schedule
// round constant and the MixColumns datapath.
package aes_pkg;

  localparam int         NR_128    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Bus-side handshake bundle of the AES round controller: one request
// channel carrying a plaintext/key pair, one response channel carrying
// the ciphertext. The master is the bus adapter, the slave the controller.
interface aes_round_ctrl_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext
  );

endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the AES-128 key schedule. Load restarts the
// sequence at 01; advance steps it by one GF(2^8) doubling, giving
// 01,02,04,08,10,20,40,80,1B,36 over ten rounds.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  // Load has priority over advance; otherwise hold the current constant.
  always_comb begin
    rcon_d = rcon_q;
    if (load_i) begin
      rcon_d = RCON_INIT;
    end else if (adv_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  // Constant register, seeded with the first round constant on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer. Accepts a plaintext/key pair,
// applies the initial AddRoundKey itself, then drives an external
// combinational round datapath and key-expansion stage once per cycle for
// NR rounds and holds the ciphertext until the consumer takes it.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = NR_128,
  parameter int RND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  aes_round_ctrl_if.slave    bus,
  output logic               busy,
  output logic [RND_W-1:0]   round_o,
  output logic [127:0]       rnd_state_o,
  output logic [127:0]       rnd_key_o,
  output logic               rnd_final_o,
  input  logic [127:0]       rnd_state_i,
  output logic [127:0]       kx_key_o,
  output logic [7:0]         kx_rcon_o,
  input  logic [127:0]       kx_key_i
);

  aes_state_e       fsm_q;
  aes_state_e       fsm_d;
  logic [127:0]     state_q;
  logic [127:0]     state_d;
  logic [127:0]     key_q;
  logic [127:0]     key_d;
  logic [RND_W-1:0] round_q;
  logic [RND_W-1:0] round_d;
  logic             rcon_load;
  logic             rcon_adv;
  logic             last_round;
  logic [7:0]       rcon;

  assign last_round = (round_q == RND_W'(NR));

  aes_rcon_gen u_rcon_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (rcon_load),
    .adv_i  (rcon_adv),
    .rcon_o (rcon)
  );

  // Next-state logic: accept a pair in IDLE, step one round per cycle in
  // ROUND, and wait in DONE until the consumer takes the result.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    key_d     = key_q;
    round_d   = round_q;
    rcon_load = 1'b0;
    rcon_adv  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d   = bus.plaintext ^ bus.key;
          key_d     = bus.key;
          round_d   = RND_W'(1);
          rcon_load = 1'b1;
          fsm_d     = ROUND;
        end
      end
      ROUND: begin
        state_d  = rnd_state_i;
        key_d    = kx_key_i;
        round_d  = round_q + RND_W'(1);
        rcon_adv = 1'b1;
        if (last_round) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          round_d = '0;
          fsm_d   = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State, key, round counter and FSM registers; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign bus.in_ready   = (fsm_q == IDLE);
  assign bus.out_valid  = (fsm_q == DONE);
  assign bus.ciphertext = state_q;
  assign busy           = (fsm_q != IDLE);
  assign round_o        = round_q;

  assign rnd_state_o = state_q;
  assign rnd_key_o   = kx_key_i;
  assign rnd_final_o = (fsm_q == ROUND) && last_round;
  assign kx_key_o    = key_q;
  assign kx_rcon_o   = rcon;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl. An independent AES-128 round and
// key-expansion model (S-box computed from the GF(2^8) inverse and affine
// map) plays the external datapath; results are checked against the
// FIPS-197 Appendix B and C.1 vectors.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ARK_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ARK_C  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst;
  logic         busy;
  logic [3:0]   roundOut;
  logic [127:0] rndStateOut;
  logic [127:0] rndKeyOut;
  logic         rndFinal;
  logic [127:0] rndStateIn;
  logic [127:0] kxKeyOut;
  logic [7:0]   kxRcon;
  logic [127:0] kxKeyIn;

  int compareCount  = 0;
  int mismatchCount = 0;
  logic [7:0] rconTab [10];

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(
    .NR    (10),
    .RND_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .round_o     (roundOut),
    .rnd_state_o (rndStateOut),
    .rnd_key_o   (rndKeyOut),
    .rnd_final_o (rndFinal),
    .rnd_state_i (rndStateIn),
    .kx_key_o    (kxKeyOut),
    .kx_rcon_o   (kxRcon),
    .kx_key_i    (kxKeyIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tbXtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = tbXtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as x^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] st,
                                            input logic [127:0] rk,
                                            input logic fin);
    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    mc = sr;
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[127-8*(4*c)   -: 8];
        a1 = sr[127-8*(4*c+1) -: 8];
        a2 = sr[127-8*(4*c+2) -: 8];
        a3 = sr[127-8*(4*c+3) -: 8];
        mc[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        mc[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        mc[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        mc[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    return mc ^ rk;
  endfunction

  function automatic logic [127:0] keyExpand(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign kxKeyIn    = keyExpand(kxKeyOut, kxRcon);
  assign rndStateIn = aesRound(rndStateOut, rndKeyOut, rndFinal);

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Present one pair for a single accept edge, then scramble the inputs.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k);
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    stepClk();
    bus.in_valid  = 1'b0;
    bus.plaintext = ~pt;
    bus.key       = ~k;
  endtask

  initial begin
    int t1;
    int t2;
    int pulses;

    rconTab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    repeat (2) @(posedge clk);
    #1;

    checkOutput("reset in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("reset out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("reset busy", 128'(busy), 128'd0);
    checkOutput("reset ciphertext", bus.ciphertext, 128'd0);
    checkOutput("reset round", 128'(roundOut), 128'd0);
    checkOutput("reset rcon", 128'(kxRcon), 128'h01);
    checkOutput("reset kx_key", kxKeyOut, 128'd0);
    rst = 1'b0;
    stepClk();

    $display("[TB] FIPS-197 App. B run");
    applyStimulus(PT_B, KEY_B);
    checkOutput("B ark state", rndStateOut, ARK_B);
    checkOutput("B key reg", kxKeyOut, KEY_B);
    checkOutput("B busy", 128'(busy), 128'd1);
    checkOutput("B in_ready", 128'(bus.in_ready), 128'd0);
    for (int r = 1; r <= 10; r++) begin
      checkOutput($sformatf("B rcon r%0d", r), 128'(kxRcon), 128'(rconTab[r-1]));
      checkOutput($sformatf("B round r%0d", r), 128'(roundOut), 128'(r));
      checkOutput($sformatf("B final r%0d", r), 128'(rndFinal), 128'(r == 10));
      checkOutput($sformatf("B out_valid r%0d", r), 128'(bus.out_valid), 128'd0);
      stepClk();
    end
    checkOutput("B out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("B ciphertext", bus.ciphertext, CT_B);

    $display("[TB] Backpressure window");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.plaintext = PT_C;
        bus.key       = KEY_C;
        bus.in_valid  = 1'b1;
      end
      checkOutput($sformatf("bp ciphertext c%0d", i), bus.ciphertext, CT_B);
      checkOutput($sformatf("bp out_valid c%0d", i), 128'(bus.out_valid), 128'd1);
      checkOutput($sformatf("bp in_ready c%0d", i), 128'(bus.in_ready), 128'd0);
      stepClk();
    end
    checkOutput("bp round held", 128'(roundOut), 128'd11);
    checkOutput("bp ciphertext end", bus.ciphertext, CT_B);
    bus.out_ready = 1'b1;
    stepClk();
    bus.out_ready = 1'b0;
    checkOutput("bp idle in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("bp idle out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("bp idle round", 128'(roundOut), 128'd0);
    stepClk();
    bus.in_valid  = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    checkOutput("C2 ark state", rndStateOut, ARK_C);
    checkOutput("C2 round", 128'(roundOut), 128'd1);
    repeat (9) stepClk();
    checkOutput("C2 out_valid early", 128'(bus.out_valid), 128'd0);
    stepClk();
    checkOutput("C2 out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("C2 ciphertext", bus.ciphertext, CT_C);
    bus.out_ready = 1'b1;
    stepClk();
    bus.out_ready = 1'b0;

    $display("[TB] Reset during round 5");
    applyStimulus(PT_B, KEY_B);
    repeat (4) stepClk();
    checkOutput("rst round before", 128'(roundOut), 128'd5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("rst out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("rst busy", 128'(busy), 128'd0);
    checkOutput("rst ciphertext", bus.ciphertext, 128'd0);
    checkOutput("rst round", 128'(roundOut), 128'd0);
    checkOutput("rst rcon", 128'(kxRcon), 128'h01);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stepClk();
    applyStimulus(PT_C, KEY_C);
    checkOutput("C1 ark state", rndStateOut, ARK_C);
    checkOutput("C1 rcon", 128'(kxRcon), 128'h01);
    repeat (10) stepClk();
    checkOutput("C1 out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("C1 ciphertext", bus.ciphertext, CT_C);
    bus.out_ready = 1'b1;
    stepClk();

    $display("[TB] Back-to-back issue");
    bus.plaintext = PT_B;
    bus.key       = KEY_B;
    bus.in_valid  = 1'b1;
    t1     = -1;
    t2     = -1;
    pulses = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      stepClk();
      if (bus.out_valid) begin
        pulses++;
        if (pulses == 1) t1 = cyc;
        else if (pulses == 2) t2 = cyc;
        checkOutput($sformatf("b2b ciphertext p%0d", pulses), bus.ciphertext, CT_B);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checkOutput("b2b pulse count", 128'(pulses), 128'd3);
    checkOutput("b2b first pulse", 128'(t1), 128'd11);
    checkOutput("b2b interval", 128'(t2 - t1), 128'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
